csa_mw_seq: RTL
===============

// Module: csa_mw_seq
// PURPOSE
//   Multi-byte adder sequencer around one shared 8-bit carry-select adder (CSA_8, no carry-in).
//   Adds two NBYTES*8-bit operands byte-serially, LSB first. Carry is chained by an extra
//   "+1" pass through the same CSA whenever a byte has an incoming carry.
//   Sits between a requester (start/done) and a CSA_8 instance wired to the csa_* ports.
// PARAMETERS
//   NBYTES  4  operand width in bytes (>=1); operand/result width W = 8*NBYTES
// PORTS
//   clk        in   1    single clock, rising edge
//   rst        in   1    synchronous, active-high reset
//   start      in   1    request; accepted only when ready=1
//   op_a       in   W    operand A, sampled on the accepting edge
//   op_b       in   W    operand B, sampled on the accepting edge
//   sub        in   1    subtract select (used only with CSA_SEQ_SUB_EN; ignored otherwise)
//   ready      out  1    1 in IDLE only
//   done       out  1    one-cycle pulse: result/carry_out valid
//   result     out  W    sum, held from done until the next accepted start
//   carry_out  out  1    carry out of MSB byte, held like result
//   csa_a      out  8    to CSA_8.A
//   csa_b      out  8    to CSA_8.B
//   csa_sum    in   8    from CSA_8.sum (combinational)
//   csa_carry  in   1    from CSA_8.carry (combinational)
// BEHAVIOUR
//   Reset: state=IDLE, ready=1, done=0, result=0, carry_out=0, csa_a=csa_b=0, idx=0, cin=0.
//   Reset mid-operation aborts immediately; no done pulse, outputs take reset values.
//   States: IDLE, ADD, INC, DONE.
//   IDLE : csa_a=csa_b=0. start=1 -> latch op_a/op_b, idx<=0, cin<=0, go ADD.
//   ADD  : csa_a=a[idx], csa_b=b[idx].
//          cin=0 -> result[idx]<=csa_sum, cin<=csa_carry; advance.
//          cin=1 -> tmp<=csa_sum, c1<=csa_carry; go INC.
//   INC  : csa_a=tmp, csa_b=8'h01; result[idx]<=csa_sum, cin<=c1|csa_carry; advance.
//   advance: idx<NBYTES-1 -> idx<=idx+1, go ADD; else carry_out<=final cin, go DONE.
//   DONE : done=1 for exactly this cycle, csa_a=csa_b=0; go IDLE.
//   Latency: done high after NBYTES+k rising edges following the accepting edge,
//     k = number of bytes entered with cin=1 (0..NBYTES).
//   start while ready=0 is ignored (not queued); operand changes after acceptance ignored.
//   Arithmetic modulo 2^W; c1 and csa_carry never both 1 in INC (no double carry).
//   result keeps previous value until overwritten byte by byte during the next operation.
// CONFIGURATION
//   CSA_SEQ_SUB_EN defined: start with sub=1 latches ~op_b and cin<=1 (two's complement
//     A-B); carry_out=1 means no borrow (A>=B). sub latched on acceptance.
//   CSA_SEQ_SUB_EN undefined: sub port present but ignored; add only, initial cin=0.
// TESTING (NBYTES=4)
//   A=0x00000005,B=0x00000006 start -> result 0x0000000B, carry_out 0, done after 4 edges.
//   A=0x000000FF,B=0x00000001 -> 0x00000100, carry_out 0, one INC, done after 5 edges.
//   A=0xFFFFFFFF,B=0x00000001 -> 0x00000000, carry_out 1, three INC, done after 7 edges.
//   start pulsed mid-op with new operands -> ignored; first result intact, single done.
//   rst asserted 2 cycles after start -> next cycle ready=1, done=0, result=0, no done.
//   CSA_SEQ_SUB_EN: 5-6 -> 0xFFFFFFFF, carry_out 0; 6-5 -> 0x00000001, carry_out 1.

Source files
------------

// File: rtl/csa_mw_seq.sv
// Byte-serial multi-byte adder sequencing one shared 8-bit carry-select adder (no carry-in).
// Optional subtract mode enabled by defining CSA_SEQ_SUB_EN.
module csa_mw_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                sub,
  output logic                ready,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic [7:0]          csa_a,
  output logic [7:0]          csa_b,
  input  logic [7:0]          csa_sum,
  input  logic                csa_carry
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              cin_q, cin_d;
  logic [W-1:0]      result_q, result_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [7:0]        tmp_q, tmp_d;
  logic              c1_q, c1_d;

  logic [W-1:0]      b_in;
  logic              cin_init;
  logic [IDXW+2:0]   bofs;
  logic              last;
  logic              cin_adv;

`ifdef CSA_SEQ_SUB_EN
  // Two's complement subtract: invert B and inject the +1 through the initial carry.
  assign b_in     = sub ? ~op_b : op_b;
  assign cin_init = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = op_b;
  assign cin_init   = 1'b0;
`endif

  assign bofs = {idx_q, 3'b000};
  assign last = (idx_q == IDXW'(NBYTES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    result_d = result_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    tmp_d    = tmp_q;
    c1_d     = c1_q;
    csa_a    = 8'h00;
    csa_b    = 8'h00;
    cin_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = b_in;
          idx_d   = '0;
          cin_d   = cin_init;
          state_d = ADD;
        end
      end
      ADD: begin
        csa_a = a_q[bofs +: 8];
        csa_b = b_q[bofs +: 8];
        if (!cin_q) begin
          result_d[bofs +: 8] = csa_sum;
          cin_adv             = csa_carry;
          cin_d               = cin_adv;
          if (last) begin
            carry_d = cin_adv;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ADD;
          end
        end else begin
          tmp_d   = csa_sum;
          c1_d    = csa_carry;
          state_d = INC;
        end
      end
      INC: begin
        // Carry propagation reuses the same adder as a +1 pass; c1 and this carry are exclusive.
        csa_a               = tmp_q;
        csa_b               = 8'h01;
        result_d[bofs +: 8] = csa_sum;
        cin_adv             = c1_q | csa_carry;
        cin_d               = cin_adv;
        if (last) begin
          carry_d = cin_adv;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    tmp_q <= tmp_d;
    c1_q  <= c1_d;
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
endmodule
